bus_arbiter: RTL

- Two-master arbiter and sequencer for the shared system bus, placed in front of the address-decode block.
- Requester 0 is the load/store unit and requester 1 is instruction fetch.
- The block grants one requester at a time, drives the shared bus address, data and control, and watches the decoder's combined device-select flag.
- It sequences one transaction to completion, returns read data, and flags unmapped or timed-out accesses as errors.

---
 rtl/bus_arbiter_if.sv | 64 ++++++
 rtl/bus_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Requester, shared-bus and status signals of bus_arbiter.
// master = arbiter side, slave = requesters plus address decoder/device.
interface bus_arbiter_if;
  logic        i_req0_valid;
  logic [31:0] i_req0_address;
  logic [31:0] i_req0_wdata;
  logic        i_req0_we;
  logic [3:0]  i_req0_be;
  logic        o_req0_done;
  logic [31:0] o_req0_rdata;
  logic        o_req0_err;

  logic        i_req1_valid;
  logic [31:0] i_req1_address;
  logic [31:0] i_req1_wdata;
  logic        i_req1_we;
  logic [3:0]  i_req1_be;
  logic        o_req1_done;
  logic [31:0] o_req1_rdata;
  logic        o_req1_err;

  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic        o_bus_start;
  logic        i_bus_mapped;
  logic        i_bus_done;
  logic [31:0] i_bus_rdata;
  logic        o_busy;

`ifdef BUS_ARB_STATS_EN
  logic [31:0] o_grant0_count;
  logic [31:0] o_grant1_count;
  logic [31:0] o_conflict_count;
  logic [31:0] o_error_count;
`endif

  modport master (
`ifdef BUS_ARB_STATS_EN
    output o_grant0_count, o_grant1_count, o_conflict_count, o_error_count,
`endif
    input  i_req0_valid, i_req0_address, i_req0_wdata, i_req0_we, i_req0_be,
    output o_req0_done, o_req0_rdata, o_req0_err,
    input  i_req1_valid, i_req1_address, i_req1_wdata, i_req1_we, i_req1_be,
    output o_req1_done, o_req1_rdata, o_req1_err,
    output o_bus_address, o_bus_wdata, o_bus_we, o_bus_be, o_bus_start,
    input  i_bus_mapped, i_bus_done, i_bus_rdata,
    output o_busy
  );

  modport slave (
`ifdef BUS_ARB_STATS_EN
    input  o_grant0_count, o_grant1_count, o_conflict_count, o_error_count,
`endif
    output i_req0_valid, i_req0_address, i_req0_wdata, i_req0_we, i_req0_be,
    input  o_req0_done, o_req0_rdata, o_req0_err,
    output i_req1_valid, i_req1_address, i_req1_wdata, i_req1_we, i_req1_be,
    input  o_req1_done, o_req1_rdata, o_req1_err,
    input  o_bus_address, o_bus_wdata, o_bus_we, o_bus_be, o_bus_start,
    output i_bus_mapped, i_bus_done, i_bus_rdata,
    input  o_busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared system bus (stats behind BUS_ARB_STATS_EN).
// Latency: done pulses 2 cycles after grant for a fast or unmapped access, up to 2+TIMEOUT_CYCLES.
// Backpressure: requesters hold valid until their done pulse; one transaction in flight at a time.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  bus_arbiter_if.master bus
);

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state, state_nxt;
  req_t               req0, req1, bus_q;
  logic               last_grant, grant;
  logic               any_req, tie, pick, expired;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        resp_rdata;
  logic               resp_err;

  assign req0 = '{bus.i_req0_address, bus.i_req0_wdata, bus.i_req0_we, bus.i_req0_be};
  assign req1 = '{bus.i_req1_address, bus.i_req1_wdata, bus.i_req1_we, bus.i_req1_be};

  // A tie goes to whoever was not served last; a lone request wins outright.
  assign any_req = bus.i_req0_valid | bus.i_req1_valid;
  assign tie     = bus.i_req0_valid & bus.i_req1_valid;
  assign pick    = tie ? ~last_grant : bus.i_req1_valid;
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (!bus.i_bus_mapped || bus.i_bus_done) ? S_RESP : S_WAIT;
      S_WAIT:  if (bus.i_bus_done || expired) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      bus_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            bus_q      <= pick ? req1 : req0;
          end
        end
        S_ISSUE: begin
          cnt        <= '0;
          resp_err   <= ~bus.i_bus_mapped;
          resp_rdata <= (bus.i_bus_mapped && bus.i_bus_done) ? bus.i_bus_rdata : '0;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // Completion outranks expiry when both land in the same cycle.
          if (bus.i_bus_done) begin
            resp_rdata <= bus.i_bus_rdata;
            resp_err   <= 1'b0;
          end else if (expired) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_bus_start  = (state == S_ISSUE);
    bus.o_busy       = (state != S_IDLE);
    bus.o_req0_done  = 1'b0;
    bus.o_req0_rdata = '0;
    bus.o_req0_err   = 1'b0;
    bus.o_req1_done  = 1'b0;
    bus.o_req1_rdata = '0;
    bus.o_req1_err   = 1'b0;
    if (state == S_RESP) begin
      if (grant) begin
        bus.o_req1_done  = 1'b1;
        bus.o_req1_rdata = resp_rdata;
        bus.o_req1_err   = resp_err;
      end else begin
        bus.o_req0_done  = 1'b1;
        bus.o_req0_rdata = resp_rdata;
        bus.o_req0_err   = resp_err;
      end
    end
  end

  assign bus.o_bus_address = bus_q.address;
  assign bus.o_bus_wdata   = bus_q.wdata;
  assign bus.o_bus_we      = bus_q.we;
  assign bus.o_bus_be      = bus_q.be;

`ifdef BUS_ARB_STATS_EN
  logic [31:0] grant0_cnt, grant1_cnt, conflict_cnt, error_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
      error_cnt    <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        if (pick) grant1_cnt <= grant1_cnt + 1'b1;
        else      grant0_cnt <= grant0_cnt + 1'b1;
        if (tie)  conflict_cnt <= conflict_cnt + 1'b1;
      end
      if (state == S_RESP && resp_err) error_cnt <= error_cnt + 1'b1;
    end
  end

  assign bus.o_grant0_count   = grant0_cnt;
  assign bus.o_grant1_count   = grant1_cnt;
  assign bus.o_conflict_count = conflict_cnt;
  assign bus.o_error_count    = error_cnt;
`endif

endmodule
